// File: rtl/sram_ctrl_pkg.sv
// Shared types and widths for the cache-side SRAM backing-store controller.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W     = 17;
  localparam int WORD_W          = 32;
  localparam int HALF_W          = 16;
  localparam int MAX_WAIT_CYCLES = 15;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP_LO  = 3'd1,
    ST_STROBE_LO = 3'd2,
    ST_SETUP_HI  = 3'd3,
    ST_STROBE_HI = 3'd4,
    ST_DONE      = 3'd5
  } sram_state_t;

endpackage

// File: rtl/sram_controller_if.sv
// Cache-side request bus: single-word read/write requests and the stall back.
interface sram_controller_if;
  import sram_ctrl_pkg::*;

  logic                   rd_sram;
  logic                   wr_sram;
  logic [SRAM_ADDR_W-1:0] addr;
  logic [WORD_W-1:0]      wr_data;
  logic [WORD_W-1:0]      rd_data;
  logic                   sram_stalled;

  modport master (
    output rd_sram, wr_sram, addr, wr_data,
    input  rd_data, sram_stalled
  );

  modport slave (
    input  rd_sram, wr_sram, addr, wr_data,
    output rd_data, sram_stalled
  );

endinterface

// File: rtl/sram_wait_counter.sv
// 4-bit loadable down-counter that times the strobe-low phase of each half access.
module sram_wait_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_value,
  output logic [3:0] value,
  output logic       zero
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load takes priority over decrement; the caller only decrements while non-zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec) begin
      count_d = count_q - 4'd1;
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign value = count_q;
  assign zero  = (count_q == 4'd0);

endmodule

// File: rtl/sram_controller.sv
// Turns one 32-bit cache request into two 16-bit asynchronous SRAM accesses
// (low half first) with programmable strobe width; all pins are registered.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_controller_if.slave       bus,
  output logic [SRAM_ADDR_W:0]   ext_addr,
  output logic [HALF_W-1:0]      ext_dq_out,
  input  logic [HALF_W-1:0]      ext_dq_in,
  output logic                   ext_dq_oe,
  output logic                   ext_ce_n,
  output logic                   ext_oe_n,
  output logic                   ext_we_n
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  sram_state_t            state_q, state_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;
  logic                   is_write_q, is_write_d;
  logic [WORD_W-1:0]      rd_data_q, rd_data_d;
  logic [SRAM_ADDR_W:0]   ext_addr_q, ext_addr_d;
  logic [HALF_W-1:0]      ext_dq_out_q, ext_dq_out_d;
  logic                   ext_dq_oe_q, ext_dq_oe_d;
  logic                   ext_ce_n_q, ext_ce_n_d;
  logic                   ext_oe_n_q, ext_oe_n_d;
  logic                   ext_we_n_q, ext_we_n_d;

  logic                   in_setup, in_strobe;
  logic                   cnt_zero;
  logic [3:0]             cnt_value;
  logic                   nxt_access, nxt_strobe, nxt_hi;

  assign in_setup  = (state_q == ST_SETUP_LO)  || (state_q == ST_SETUP_HI);
  assign in_strobe = (state_q == ST_STROBE_LO) || (state_q == ST_STROBE_HI);

  sram_wait_counter u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (in_setup),
    .dec        (in_strobe && (cnt_value != 4'd0)),
    .load_value (WAIT_LOAD),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  // Sequencing: latch the request in IDLE, walk both halves, capture read data at strobe end.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.rd_sram || bus.wr_sram) begin
          addr_d     = bus.addr;
          wdata_d    = bus.wr_data;
          is_write_d = !bus.rd_sram;
          state_d    = ST_SETUP_LO;
        end
      end
      ST_SETUP_LO: state_d = ST_STROBE_LO;
      ST_STROBE_LO: begin
        if (cnt_zero) begin
          if (!is_write_q) rd_data_d[HALF_W-1:0] = ext_dq_in;
          state_d = ST_SETUP_HI;
        end
      end
      ST_SETUP_HI: state_d = ST_STROBE_HI;
      ST_STROBE_HI: begin
        if (cnt_zero) begin
          if (!is_write_q) rd_data_d[WORD_W-1:HALF_W] = ext_dq_in;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so the registered pins line up with it.
  always_comb begin
    nxt_access   = (state_d == ST_SETUP_LO) || (state_d == ST_STROBE_LO) ||
                   (state_d == ST_SETUP_HI) || (state_d == ST_STROBE_HI);
    nxt_strobe   = (state_d == ST_STROBE_LO) || (state_d == ST_STROBE_HI);
    nxt_hi       = (state_d == ST_SETUP_HI) || (state_d == ST_STROBE_HI);
    ext_addr_d   = ext_addr_q;
    ext_dq_out_d = ext_dq_out_q;
    if (nxt_access) begin
      ext_addr_d   = {addr_d, nxt_hi};
      ext_dq_out_d = nxt_hi ? wdata_d[WORD_W-1:HALF_W] : wdata_d[HALF_W-1:0];
    end
    ext_ce_n_d  = !nxt_access;
    ext_oe_n_d  = !(nxt_strobe && !is_write_d);
    ext_we_n_d  = !(nxt_strobe && is_write_d);
    ext_dq_oe_d = nxt_access && is_write_d;
  end

  // State and pin registers; reset discards any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      is_write_q   <= 1'b0;
      rd_data_q    <= '0;
      ext_addr_q   <= '0;
      ext_dq_out_q <= '0;
      ext_dq_oe_q  <= 1'b0;
      ext_ce_n_q   <= 1'b1;
      ext_oe_n_q   <= 1'b1;
      ext_we_n_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      is_write_q   <= is_write_d;
      rd_data_q    <= rd_data_d;
      ext_addr_q   <= ext_addr_d;
      ext_dq_out_q <= ext_dq_out_d;
      ext_dq_oe_q  <= ext_dq_oe_d;
      ext_ce_n_q   <= ext_ce_n_d;
      ext_oe_n_q   <= ext_oe_n_d;
      ext_we_n_q   <= ext_we_n_d;
    end
  end

  assign ext_addr         = ext_addr_q;
  assign ext_dq_out       = ext_dq_out_q;
  assign ext_dq_oe        = ext_dq_oe_q;
  assign ext_ce_n         = ext_ce_n_q;
  assign ext_oe_n         = ext_oe_n_q;
  assign ext_we_n         = ext_we_n_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.sram_stalled = (bus.rd_sram || bus.wr_sram) && (reset || (state_q != ST_DONE));

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller at 2, 1 and 15 wait states.
module tb_sram_controller;

  localparam int WC [3] = '{2, 1, 15};

  logic        clk;
  logic        reset;
  int          sel;
  logic        req_rd, req_wr;
  logic [16:0] req_addr;
  logic [31:0] req_data;

  logic [17:0] ea     [3];
  logic [15:0] dq_out [3];
  logic [15:0] dq_in  [3];
  logic        dq_oe  [3];
  logic        ce_n   [3];
  logic        oe_n   [3];
  logic        we_n   [3];
  logic        stall  [3];
  logic [31:0] rdd    [3];

  int   n_checks = 0;
  int   n_errors = 0;
  int   done_cyc, stall_hi, we_total, oe_total, lo_ok, hi_ok;
  logic stall_at_done;

  // SRAM read model: two fixed words for the read scenario, a simple pattern elsewhere.
  function automatic logic [15:0] sramRead(input logic [17:0] ha);
    case (ha)
      18'h00A0B: return 16'hBEEF;
      18'h00A0A: return 16'hDEAD;
      default:   return ha[15:0] ^ 16'hA5A5;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_controller_if bus ();
    assign bus.rd_sram = (sel == g) && req_rd;
    assign bus.wr_sram = (sel == g) && req_wr;
    assign bus.addr    = req_addr;
    assign bus.wr_data = req_data;
    assign rdd[g]      = bus.rd_data;
    assign stall[g]    = bus.sram_stalled;
    assign dq_in[g]    = oe_n[g] ? 16'h0000 : sramRead(ea[g]);
    sram_controller #(.WAIT_CYCLES(WC[g])) u_dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .ext_addr   (ea[g]),
      .ext_dq_out (dq_out[g]),
      .ext_dq_in  (dq_in[g]),
      .ext_dq_oe  (dq_oe[g]),
      .ext_ce_n   (ce_n[g]),
      .ext_oe_n   (oe_n[g]),
      .ext_we_n   (we_n[g])
    );
  end

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request on DUT s and observe it cycle by cycle until DONE (ce_n back high).
  task automatic applyStimulus(input int s, input logic rd, input logic wr,
                               input logic [16:0] a, input logic [31:0] d,
                               input int change_at, input int bound);
    bit seen_ce;
    seen_ce = 0;
    done_cyc = -1; stall_hi = 0; we_total = 0; oe_total = 0; lo_ok = 0; hi_ok = 0;
    stall_at_done = 1'b1;
    @(negedge clk);
    sel = s; req_addr = a; req_data = d; req_rd = rd; req_wr = wr;
    for (int k = 0; k <= bound; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (ce_n[sel] && seen_ce) begin
        done_cyc = k;
        stall_at_done = stall[sel];
        break;
      end
      if (!ce_n[sel]) seen_ce = 1;
      if (stall[sel]) stall_hi++;
      if (!we_n[sel]) begin
        we_total++;
        if (dq_oe[sel] && ea[sel] == {a, 1'b0} && dq_out[sel] == d[15:0])  lo_ok++;
        if (dq_oe[sel] && ea[sel] == {a, 1'b1} && dq_out[sel] == d[31:16]) hi_ok++;
      end
      if (!oe_n[sel]) begin
        oe_total++;
        if (ea[sel] == {a, 1'b0}) lo_ok++;
        if (ea[sel] == {a, 1'b1}) hi_ok++;
      end
      if (k == change_at) begin
        req_addr = 17'h1AAAA; req_data = 32'h0; req_rd = 1'b0; req_wr = 1'b0;
      end
    end
    req_rd = 1'b0; req_wr = 1'b0;
  endtask

  initial begin
    int gap;
    int rcyc;
    reset = 1'b1; sel = 0; req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_ce_n", 32'(ce_n[0]), 32'h1);
    checkOutput("reset_rd_data", rdd[0], 32'h0);
    checkOutput("reset_stall_idle", 32'(stall[0]), 32'h0);
    checkOutput("reset_ext_addr", 32'(ea[0]), 32'h0);
    reset = 1'b0;

    // Read of 0x0505 with 2 wait states.
    applyStimulus(0, 1'b1, 1'b0, 17'h0505, 32'h0, -1, 60);
    checkOutput("rd_done_cycle", 32'(done_cyc), 32'd7);
    checkOutput("rd_stall_cycles", 32'(stall_hi), 32'd7);
    checkOutput("rd_stall_at_done", 32'(stall_at_done), 32'h0);
    checkOutput("rd_data", rdd[0], 32'hBEEFDEAD);
    checkOutput("rd_oe_cycles", 32'(oe_total), 32'd4);
    checkOutput("rd_we_cycles", 32'(we_total), 32'd0);
    checkOutput("rd_lo_hi", 32'({lo_ok[7:0], hi_ok[7:0]}), 32'h0202);

    // Write at the top of the address space.
    applyStimulus(0, 1'b0, 1'b1, 17'h1FFFF, 32'h12345678, -1, 60);
    checkOutput("wr_done_cycle", 32'(done_cyc), 32'd7);
    checkOutput("wr_stall_cycles", 32'(stall_hi), 32'd7);
    checkOutput("wr_we_cycles", 32'(we_total), 32'd4);
    checkOutput("wr_oe_cycles", 32'(oe_total), 32'd0);
    checkOutput("wr_lo_hi", 32'({lo_ok[7:0], hi_ok[7:0]}), 32'h0202);
    checkOutput("wr_rd_data_kept", rdd[0], 32'hBEEFDEAD);

    // Inputs change and the request drops during STROBE_LO.
    applyStimulus(0, 1'b0, 1'b1, 17'h00123, 32'hCAFEF00D, 2, 60);
    checkOutput("mid_done_cycle", 32'(done_cyc), 32'd7);
    checkOutput("mid_we_cycles", 32'(we_total), 32'd4);
    checkOutput("mid_lo_hi", 32'({lo_ok[7:0], hi_ok[7:0]}), 32'h0202);

    // Reset during STROBE_HI of a write, request held through reset.
    @(negedge clk);
    sel = 0; req_addr = 17'h00300; req_data = 32'h11112222; req_wr = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("rst_pre_we_n", 32'(we_n[0]), 32'h0);
    checkOutput("rst_pre_addr", 32'(ea[0]), 32'h00601);
    reset = 1'b1;
    #1;
    checkOutput("rst_stall_in_reset", 32'(stall[0]), 32'h1);
    @(negedge clk);
    #1;
    checkOutput("rst_strobes", 32'({ce_n[0], oe_n[0], we_n[0], dq_oe[0]}), 32'hE);
    checkOutput("rst_rd_data", rdd[0], 32'h0);
    checkOutput("rst_addr_dq", {14'h0, ea[0]} ^ {16'h0, dq_out[0]}, 32'h0);
    checkOutput("rst_stall_held", 32'(stall[0]), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst_restart_lo", 32'({ce_n[0], we_n[0], dq_oe[0]}), 32'h3);
    checkOutput("rst_restart_addr", 32'(ea[0]), 32'h00600);
    checkOutput("rst_restart_dq", 32'(dq_out[0]), 32'h2222);
    rcyc = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (ce_n[0]) begin
        rcyc = k;
        break;
      end
    end
    req_wr = 1'b0;
    checkOutput("rst_restart_done", 32'(rcyc), 32'd7);

    // Back-to-back: read, then a write raised in the DONE cycle.
    applyStimulus(0, 1'b1, 1'b0, 17'h00010, 32'h0, -1, 60);
    checkOutput("b2b_rd_data", rdd[0], 32'hA584A585);
    req_addr = 17'h00020; req_data = 32'h0F0F1E1E; req_wr = 1'b1;
    #1;
    checkOutput("b2b_stall_in_done", 32'(stall[0]), 32'h0);
    gap = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      if (!ce_n[0]) begin
        gap = k;
        break;
      end
    end
    checkOutput("b2b_setup_gap", 32'(gap), 32'd2);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      #1;
      if (ce_n[0]) break;
    end
    req_wr = 1'b0;
    checkOutput("b2b_rd_data_kept", rdd[0], 32'hA584A585);

    // Simultaneous read and write: read wins.
    applyStimulus(0, 1'b1, 1'b1, 17'h0505, 32'hFFFF0000, -1, 60);
    checkOutput("both_done_cycle", 32'(done_cyc), 32'd7);
    checkOutput("both_we_cycles", 32'(we_total), 32'd0);
    checkOutput("both_oe_cycles", 32'(oe_total), 32'd4);
    checkOutput("both_rd_data", rdd[0], 32'hBEEFDEAD);

    // Wait-state extremes.
    applyStimulus(1, 1'b1, 1'b0, 17'h0505, 32'h0, -1, 60);
    checkOutput("w1_done_cycle", 32'(done_cyc), 32'd5);
    checkOutput("w1_oe_cycles", 32'(oe_total), 32'd2);
    checkOutput("w1_rd_data", rdd[1], 32'hBEEFDEAD);
    applyStimulus(2, 1'b1, 1'b0, 17'h0505, 32'h0, -1, 80);
    checkOutput("w15_done_cycle", 32'(done_cyc), 32'd33);
    checkOutput("w15_oe_cycles", 32'(oe_total), 32'd30);
    checkOutput("w15_rd_data", rdd[2], 32'hBEEFDEAD);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
